// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with whole-frame debounce and a
// latched toggle map for the downstream dot-matrix display.
//
// Ports:
//   clock      system clock, rising edge
//   reset      asynchronous active-low reset
//   kp_row     row sense, active-low; kp_row[3] = row 0 .. kp_row[0] = row 3
//   clr        synchronous clear of kp_val
//   kp_col     column drive, active-low one-cold; kp_col[3] = col 0 .. kp_col[0] = col 3
//   kp_val     toggle map; key (r,c) owns bit 15-(4r+c)
//   key_code   index 4r+c of the last accepted new press
//   key_valid  one-cycle pulse qualifying key_code
module keypad_scanner #(
    parameter int unsigned SCAN_DIV = 1000,
    parameter int unsigned DEBOUNCE = 3
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [3:0]  kp_row,
    input  logic        clr,
    output logic [3:0]  kp_col,
    output logic [15:0] kp_val,
    output logic [3:0]  key_code,
    output logic        key_valid
);

    localparam int unsigned DivW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned CntW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    typedef enum logic [1:0] {StDrive, StSample, StEval} state_t;

    state_t            state;
    logic [1:0]        col;
    logic [DivW-1:0]   div;
    logic [15:0]       raw;
    logic [15:0]       prev;
    logic [15:0]       deb;
    logic [CntW-1:0]   match_cnt;

    logic [15:0]       raw_next;
    logic [CntW-1:0]   match_next;
    logic [15:0]       deb_next;
    logic [15:0]       rise;
    logic [3:0]        first_idx;

    // Merge the current column's row sense into the raw frame.
    always_comb begin
        raw_next = raw;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (col == 2'(c)) begin
                    raw_next[15 - (4 * r + c)] = ~kp_row[3 - r];
                end
            end
        end
    end

    // Frame-level debounce: a state must repeat over DEBOUNCE frames to be accepted.
    always_comb begin
        if (raw == prev) begin
            if (match_cnt == CntW'(DEBOUNCE - 1)) begin
                match_next = match_cnt;
            end else begin
                match_next = match_cnt + 1'b1;
            end
        end else begin
            match_next = '0;
        end
        deb_next = (match_next == CntW'(DEBOUNCE - 1)) ? raw : deb;
        rise     = deb_next & ~deb;
    end

    // Smallest key index wins; index 4r+c sits at bit 15-(4r+c), so the highest
    // set bit is kept (ascending scan, last hit wins).
    always_comb begin
        first_idx = 4'd0;
        for (int b = 0; b < 16; b++) begin
            if (rise[b]) begin
                first_idx = 4'(15 - b);
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= StDrive;
            col       <= 2'd0;
            div       <= '0;
            raw       <= '0;
            prev      <= '0;
            deb       <= '0;
            match_cnt <= '0;
            kp_col    <= 4'b1111;
            kp_val    <= '0;
            key_code  <= 4'd0;
            key_valid <= 1'b0;
        end else begin
            key_valid <= 1'b0;
            unique case (state)
                StDrive: begin
                    kp_col <= ~(4'b1000 >> col);
                    if (div == DivW'(SCAN_DIV - 1)) begin
                        div   <= '0;
                        state <= StSample;
                    end else begin
                        div <= div + 1'b1;
                    end
                end
                StSample: begin
                    // Column drive is held through the sample cycle.
                    raw <= raw_next;
                    if (col == 2'd3) begin
                        col   <= 2'd0;
                        state <= StEval;
                    end else begin
                        col   <= col + 2'd1;
                        state <= StDrive;
                    end
                end
                StEval: begin
                    kp_col    <= 4'b1111;
                    match_cnt <= match_next;
                    prev      <= raw;
                    deb       <= deb_next;
                    if (|rise) begin
                        key_valid <= 1'b1;
                        key_code  <= first_idx;
                    end
                    state <= StDrive;
                end
                default: begin
                    state <= StDrive;
                end
            endcase

            // Clear overrides a coincident toggle; only rising keys toggle.
            if (clr) begin
                kp_val <= '0;
            end else if (state == StEval) begin
                kp_val <= kp_val ^ rise;
            end
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner with SCAN_DIV=4,
// DEBOUNCE=3 (21-cycle frames). A behavioural keypad pulls rows low for
// pressed keys in the currently driven column.
module tb_keypad_scanner;

    localparam int unsigned SCAN_DIV = 4;
    localparam int unsigned DEBOUNCE = 3;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        clr   = 1'b0;
    logic [3:0]  kp_row;
    logic [3:0]  kp_col;
    logic [15:0] kp_val;
    logic [3:0]  key_code;
    logic        key_valid;

    // Pressed keys, same bit mapping as kp_val.
    logic [15:0] keys = 16'h0000;

    int tests_run    = 0;
    int tests_failed = 0;
    int pulse_cnt    = 0;

    keypad_scanner #(
        .SCAN_DIV (SCAN_DIV),
        .DEBOUNCE (DEBOUNCE)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .kp_row    (kp_row),
        .clr       (clr),
        .kp_col    (kp_col),
        .kp_val    (kp_val),
        .key_code  (key_code),
        .key_valid (key_valid)
    );

    always #5 clock = ~clock;

    always_comb begin
        kp_row = 4'hF;
        for (int r = 0; r < 4; r++) begin
            for (int c = 0; c < 4; c++) begin
                if (keys[15 - (4 * r + c)] && (kp_col[3 - c] == 1'b0)) begin
                    kp_row[3 - r] = 1'b0;
                end
            end
        end
    end

    always @(negedge clock) begin
        if (reset && key_valid) begin
            pulse_cnt <= pulse_cnt + 1;
        end
    end

    // Advance to the negedge where the post-EVAL 1111 column code is shown.
    task automatic wait_frame_end();
        int n;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (kp_col !== 4'b1111 && n < 40);
        if (kp_col !== 4'b1111) begin
            tests_run++;
            tests_failed++;
            $display("FAIL frame_timeout: kp_col=%b after %0d cycles, required 1111", kp_col, n);
        end
    endtask

    task automatic test_reset();
        logic [3:0] exp_col;
        reset = 1'b0;
        repeat (3) @(negedge clock);
        tests_run++;
        if (kp_col !== 4'b1111) begin
            tests_failed++;
            $display("FAIL reset_kp_col: got %b, required 1111", kp_col);
        end
        tests_run++;
        if (kp_val !== 16'h0000) begin
            tests_failed++;
            $display("FAIL reset_kp_val: got %h, required 0000", kp_val);
        end
        tests_run++;
        if (key_code !== 4'd0 || key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_key: got code=%0d valid=%b, required 0/0", key_code, key_valid);
        end
        reset = 1'b1;
        for (int i = 0; i < 21; i++) begin
            @(negedge clock);
            exp_col = (i == 20) ? 4'b1111 : ~(4'b1000 >> (i / 5));
            tests_run++;
            if (kp_col !== exp_col) begin
                tests_failed++;
                $display("FAIL scan_pattern[%0d]: got %b, required %b", i, kp_col, exp_col);
            end
        end
    endtask

    task automatic test_press();
        int p0;
        logic [15:0] exp_val;
        keys = 16'h8000;
        #1 p0 = pulse_cnt;
        for (int f = 1; f <= 6; f++) begin
            wait_frame_end();
            exp_val = (f >= 3) ? 16'h8000 : 16'h0000;
            tests_run++;
            if (kp_val !== exp_val) begin
                tests_failed++;
                $display("FAIL press_val f%0d: got %h, required %h", f, kp_val, exp_val);
            end
            tests_run++;
            if (key_valid !== (f == 3)) begin
                tests_failed++;
                $display("FAIL press_valid f%0d: got %b, required %b", f, key_valid, (f == 3));
            end
            if (f == 3) begin
                tests_run++;
                if (key_code !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL press_code: got %0d, required 0", key_code);
                end
            end
        end
        #1;
        tests_run++;
        if (pulse_cnt - p0 !== 1) begin
            tests_failed++;
            $display("FAIL press_pulses: got %0d, required 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_release_repress();
        int p0;
        logic [15:0] exp_val;
        keys = 16'h0000;
        #1 p0 = pulse_cnt;
        for (int f = 1; f <= 4; f++) begin
            wait_frame_end();
            tests_run++;
            if (kp_val !== 16'h8000 || key_valid !== 1'b0) begin
                tests_failed++;
                $display("FAIL release f%0d: got val=%h valid=%b, required 8000/0",
                         f, kp_val, key_valid);
            end
        end
        keys = 16'h8000;
        for (int f = 1; f <= 4; f++) begin
            wait_frame_end();
            exp_val = (f >= 3) ? 16'h0000 : 16'h8000;
            tests_run++;
            if (kp_val !== exp_val) begin
                tests_failed++;
                $display("FAIL repress_val f%0d: got %h, required %h", f, kp_val, exp_val);
            end
            if (f == 3) begin
                tests_run++;
                if (key_valid !== 1'b1 || key_code !== 4'd0) begin
                    tests_failed++;
                    $display("FAIL repress_key: got valid=%b code=%0d, required 1/0",
                             key_valid, key_code);
                end
            end
        end
        #1;
        tests_run++;
        if (pulse_cnt - p0 !== 1) begin
            tests_failed++;
            $display("FAIL repress_pulses: got %0d, required 1", pulse_cnt - p0);
        end
    endtask

    task automatic test_bounce();
        int p0;
        keys = 16'h0000;
        repeat (3) wait_frame_end();
        #1 p0 = pulse_cnt;
        for (int f = 1; f <= 5; f++) begin
            keys = (f <= 2) ? 16'h0040 : 16'h0000;
            wait_frame_end();
            tests_run++;
            if (kp_val !== 16'h0000) begin
                tests_failed++;
                $display("FAIL bounce_val f%0d: got %h, required 0000", f, kp_val);
            end
        end
        #1;
        tests_run++;
        if (pulse_cnt - p0 !== 0) begin
            tests_failed++;
            $display("FAIL bounce_pulses: got %0d, required 0", pulse_cnt - p0);
        end
    endtask

    task automatic test_simultaneous();
        int p0;
        logic [15:0] exp_val;
        keys = 16'h0201;
        #1 p0 = pulse_cnt;
        for (int f = 1; f <= 4; f++) begin
            wait_frame_end();
            exp_val = (f >= 3) ? 16'h0201 : 16'h0000;
            tests_run++;
            if (kp_val !== exp_val) begin
                tests_failed++;
                $display("FAIL multi_val f%0d: got %h, required %h", f, kp_val, exp_val);
            end
            if (f == 3) begin
                tests_run++;
                if (key_valid !== 1'b1 || key_code !== 4'd6) begin
                    tests_failed++;
                    $display("FAIL multi_key: got valid=%b code=%0d, required 1/6",
                             key_valid, key_code);
                end
            end
        end
        #1;
        tests_run++;
        if (pulse_cnt - p0 !== 1) begin
            tests_failed++;
            $display("FAIL multi_pulses: got %0d, required 1", pulse_cnt - p0);
        end
        keys = 16'h0000;
        repeat (3) wait_frame_end();
    endtask

    task automatic test_clr();
        int p0;
        clr  = 1'b1;
        keys = 16'h4000;
        #1 p0 = pulse_cnt;
        @(negedge clock);
        tests_run++;
        if (kp_val !== 16'h0000) begin
            tests_failed++;
            $display("FAIL clr_immediate: got %h, required 0000", kp_val);
        end
        repeat (3) wait_frame_end();
        tests_run++;
        if (kp_val !== 16'h0000 || key_valid !== 1'b1 || key_code !== 4'd1) begin
            tests_failed++;
            $display("FAIL clr_toggle: got val=%h valid=%b code=%0d, required 0000/1/1",
                     kp_val, key_valid, key_code);
        end
        clr = 1'b0;
        wait_frame_end();
        tests_run++;
        if (kp_val !== 16'h0000 || key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_held: got val=%h valid=%b, required 0000/0", kp_val, key_valid);
        end
        #1;
        tests_run++;
        if (pulse_cnt - p0 !== 1) begin
            tests_failed++;
            $display("FAIL clr_pulses: got %0d, required 1", pulse_cnt - p0);
        end
        keys = 16'h0000;
        repeat (3) wait_frame_end();
        keys = 16'h4000;
        repeat (3) wait_frame_end();
        tests_run++;
        if (kp_val !== 16'h4000 || key_valid !== 1'b1) begin
            tests_failed++;
            $display("FAIL clr_after: got val=%h valid=%b, required 4000/1", kp_val, key_valid);
        end
    endtask

    task automatic test_reset_mid();
        int n;
        logic [15:0] exp_val;
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (kp_col !== 4'b1101 && n < 40);
        tests_run++;
        if (kp_col !== 4'b1101) begin
            tests_failed++;
            $display("FAIL mid_wait: got kp_col=%b, required 1101", kp_col);
        end
        #2 reset = 1'b0;
        #1;
        tests_run++;
        if (kp_col !== 4'b1111 || kp_val !== 16'h0000 || key_code !== 4'd0
            || key_valid !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got col=%b val=%h code=%0d valid=%b, required 1111/0000/0/0",
                     kp_col, kp_val, key_code, key_valid);
        end
        @(negedge clock);
        reset = 1'b1;
        // Key still held: debounce restarts from cleared state and toggles once.
        for (int f = 1; f <= 3; f++) begin
            wait_frame_end();
            exp_val = (f == 3) ? 16'h4000 : 16'h0000;
            tests_run++;
            if (kp_val !== exp_val) begin
                tests_failed++;
                $display("FAIL mid_after f%0d: got %h, required %h", f, kp_val, exp_val);
            end
        end
    endtask

    initial begin
        test_reset();
        test_press();
        test_release_repress();
        test_bounce();
        test_simultaneous();
        test_clr();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
